// File: rtl/dp_ctrl_pkg.sv
// Shared constants and types for the 16-bit datapath sequencer.
// Opcodes, ALU/PC codes, FSM encoding and IR field positions.
package dp_ctrl_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_MVI  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_SUBI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

endpackage

// File: rtl/dp_ctrl_decode.sv
// Opcode decoder: classifies the instruction and picks ALU controls.
// Exactly one of the class flags is high for any opcode.
module dp_ctrl_decode
  import dp_ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [2:0] alu_func_o,
  output logic       alu_in_sel_o,
  output logic       is_alu_o,
  output logic       is_jmp_o,
  output logic       is_halt_o,
  output logic       is_nop_o,
  output logic       illegal_o
);

  always_comb begin
    alu_func_o   = ALU_PASSB;
    alu_in_sel_o = 1'b0;
    is_alu_o     = 1'b0;
    is_jmp_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_nop_o     = 1'b0;
    illegal_o    = 1'b0;
    unique case (op_i)
      OP_NOP:  is_nop_o = 1'b1;
      OP_MOV:  is_alu_o = 1'b1;
      OP_MVI: begin
        is_alu_o     = 1'b1;
        alu_in_sel_o = 1'b1;
      end
      OP_ADD: begin
        is_alu_o   = 1'b1;
        alu_func_o = ALU_ADD;
      end
      OP_SUB: begin
        is_alu_o   = 1'b1;
        alu_func_o = ALU_SUB;
      end
      OP_AND: begin
        is_alu_o   = 1'b1;
        alu_func_o = ALU_AND;
      end
      OP_OR: begin
        is_alu_o   = 1'b1;
        alu_func_o = ALU_OR;
      end
      OP_ADDI: begin
        is_alu_o     = 1'b1;
        alu_in_sel_o = 1'b1;
        alu_func_o   = ALU_ADD;
      end
      OP_SUBI: begin
        is_alu_o     = 1'b1;
        alu_in_sel_o = 1'b1;
        alu_func_o   = ALU_SUB;
      end
      OP_JMP:  is_jmp_o  = 1'b1;
      OP_HALT: is_halt_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dp_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the datapath.
// Outputs are a function of state and IR only.
module dp_ctrl_fsm
  import dp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic             dp_en_out,
  output logic             en_pc_pulse,
  output logic [1:0]       pc_ctrl,
  output logic [7:0]       offset_addr,
  output logic [7:0]       offset,
  output logic             en_in,
  output logic [3:0]       reg_en,
  output logic             alu_in_sel,
  output logic [2:0]       alu_func,
  output logic [1:0]       rd,
  output logic [1:0]       rs,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic             illegal_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             to_q, to_d;
  logic             il_q, il_d;

  logic is_alu, is_jmp, is_halt, is_nop, illegal;

  dp_ctrl_decode u_dec (
    .op_i         (ir_q[OP_HI:OP_LO]),
    .alu_func_o   (alu_func),
    .alu_in_sel_o (alu_in_sel),
    .is_alu_o     (is_alu),
    .is_jmp_o     (is_jmp),
    .is_halt_o    (is_halt),
    .is_nop_o     (is_nop),
    .illegal_o    (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      ret_q   <= '0;
      to_q    <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      to_q    <= to_d;
      il_q    <= il_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    to_d    = to_q;
    il_d    = il_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_alu: begin
            cnt_d   = '0;
            state_d = S_EXEC;
          end
          is_nop, is_jmp: begin
            ret_d   = ret_q + 1'b1;
            state_d = S_FETCH;
          end
          is_halt: begin
            ret_d   = ret_q + 1'b1;
            state_d = S_HALT;
          end
          illegal: begin
            il_d    = 1'b1;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      // completion beats timeout when both land in the same cycle
      S_EXEC: begin
        if (dp_en_out) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        ret_d   = ret_q + 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          to_d    = 1'b0;
          il_d    = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    en_pc_pulse = 1'b0;
    pc_ctrl     = PC_HOLD;
    en_in       = 1'b0;
    reg_en      = 4'b0000;
    unique case (state_q)
      S_DECODE: begin
        en_in = is_alu;
        if (is_nop) begin
          en_pc_pulse = 1'b1;
          pc_ctrl     = PC_INC;
        end else if (is_jmp) begin
          en_pc_pulse = 1'b1;
          pc_ctrl     = PC_LOAD;
        end
      end
      S_WB: begin
        reg_en      = 4'b0001 << ir_q[RD_HI:RD_LO];
        en_pc_pulse = 1'b1;
        pc_ctrl     = PC_INC;
      end
      default: ;
    endcase
  end

  assign offset_addr = ir_q[IMM_HI:IMM_LO];
  assign offset      = ir_q[IMM_HI:IMM_LO];
  assign rd          = ir_q[RD_HI:RD_LO];
  assign rs          = ir_q[RS_HI:RS_LO];
  assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted      = (state_q == S_HALT);
  assign timeout_err = to_q;
  assign illegal_err = il_q;
  assign retired     = ret_q;

endmodule
